// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared constants and the buffered entry type for the
// execute-to-memory stage.
//   - Opcode and ALU-op encodings used by the stage decode.
//   - Overflow status codes written to rstatus on an overflow rewrite.
//   - entry_t: one buffered instruction result as seen by the memory stage.
// The entry field widths are fixed here. The stage's DATA_W and REG_W
// parameters must keep their default values to match them.
package ex_mem_pkg;

   localparam int PKG_DATA_W = 32;
   localparam int PKG_REG_W  = 5;

   localparam logic [4:0] OP_ALU  = 5'b00000;
   localparam logic [4:0] OP_ADDI = 5'b00101;
   localparam logic [4:0] OP_LW   = 5'b01000;
   localparam logic [4:0] OP_SW   = 5'b00111;
   localparam logic [4:0] OP_BNE  = 5'b00010;
   localparam logic [4:0] OP_BLT  = 5'b00110;

   localparam logic [4:0] ALU_ADD = 5'b00000;
   localparam logic [4:0] ALU_SUB = 5'b00001;

   localparam int OVF_ADD  = 1;
   localparam int OVF_ADDI = 2;
   localparam int OVF_SUB  = 3;

   typedef struct packed {
      logic [PKG_REG_W-1:0]  rd;
      logic [PKG_DATA_W-1:0] result;
      logic [PKG_DATA_W-1:0] store_data;
      logic                  reg_we;
      logic                  mem_we;
      logic                  mem_re;
   } entry_t;

endpackage

// File: rtl/ex_mem_skid.sv
// ex_mem_skid: 2-entry FIFO-ordered valid/ready buffer.
// The head slot is registered and drives out_data directly. in_ready
// depends only on the registered occupancy, so a downstream stall never
// creates a combinational path back to the producer.
// Ports:
//   clock, reset (async active-low), flush (sync, empties the buffer)
//   in_valid/in_ready/in_data    : producer side
//   out_valid/out_ready/out_data : consumer side (head entry)
module ex_mem_skid
   import ex_mem_pkg::*;
#(
   parameter type T = entry_t
) (
   input  logic clock,
   input  logic reset,
   input  logic flush,
   input  logic in_valid,
   output logic in_ready,
   input  T     in_data,
   output logic out_valid,
   input  logic out_ready,
   output T     out_data
);

   logic [1:0] count_p1;
   T           head_p1;
   T           tail_p1;
   logic       push;
   logic       pop;

   assign in_ready  = (count_p1 != 2'd2);
   assign out_valid = (count_p1 != 2'd0);
   assign out_data  = head_p1;

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   // Buffer registers: head is always the oldest entry
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_p1 <= 2'd0;
         head_p1  <= '0;
         tail_p1  <= '0;
      end else if (flush) begin
         count_p1 <= 2'd0;
      end else begin
         if (pop) begin
            // At count 2 no push can happen; at count 1 a push refills head.
            if (count_p1 == 2'd2)
               head_p1 <= tail_p1;
            else if (push)
               head_p1 <= in_data;
         end else if (push) begin
            if (count_p1 == 2'd0)
               head_p1 <= in_data;
            else
               tail_p1 <= in_data;
         end

         case ({push, pop})
            2'b10:   count_p1 <= count_p1 + 2'd1;
            2'b01:   count_p1 <= count_p1 - 2'd1;
            default: count_p1 <= count_p1;
         endcase
      end
   end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute-to-memory pipeline stage downstream of the ALU.
// It decodes write enables, rewrites overflowing add/addi/sub into an
// rstatus write, resolves bne/blt into a one-cycle PC redirect, and
// buffers results in a 2-entry skid buffer.
// Ports:
//   clock, reset (async active-low), flush (sync squash of entries/redirect)
//   in_*       : ALU result, flags and control fields, in_valid/in_ready
//   out_*      : head entry toward the memory stage, out_valid/out_ready
//   redirect_* : taken-branch pulse and target
// Optional build macro EX_MEM_OVF_COUNT_EN adds ovf_count, a saturating
// count of overflow rewrites that only reset clears.
module ex_mem_stage
   import ex_mem_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int REG_W   = 5,
   parameter int OVF_RD  = 30,
   parameter int COUNT_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        in_opcode,
   input  logic [4:0]        in_aluop,
   input  logic [REG_W-1:0]  in_rd,
   input  logic [DATA_W-1:0] in_alu_result,
   input  logic              in_not_equal,
   input  logic              in_less_than,
   input  logic              in_overflow,
   input  logic [DATA_W-1:0] in_store_data,
   input  logic [DATA_W-1:0] in_branch_target,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [REG_W-1:0]  out_rd,
   output logic [DATA_W-1:0] out_result,
   output logic [DATA_W-1:0] out_store_data,
   output logic              out_reg_we,
   output logic              out_mem_we,
   output logic              out_mem_re,
   output logic              redirect_valid,
   output logic [DATA_W-1:0] redirect_pc
`ifdef EX_MEM_OVF_COUNT_EN
   ,
   output logic [COUNT_W-1:0] ovf_count
`endif
);

   entry_t     ent_p0;
   entry_t     head_p1;
   logic       accept_p0;
   logic       ovf_hit_p0;
   logic       taken_p0;
   logic [1:0] ovf_code_p0;

   assign accept_p0 = in_valid && in_ready;

   // Decode, overflow rewrite and rd=0 suppression, in that order
   always_comb begin
      ent_p0            = '0;
      ovf_hit_p0        = 1'b0;
      ovf_code_p0       = 2'd0;
      ent_p0.rd         = in_rd;
      ent_p0.result     = in_alu_result;
      ent_p0.store_data = in_store_data;

      case (in_opcode)
         OP_ALU:  ent_p0.reg_we = 1'b1;
         OP_ADDI: ent_p0.reg_we = 1'b1;
         OP_LW: begin
            ent_p0.reg_we = 1'b1;
            ent_p0.mem_re = 1'b1;
         end
         OP_SW:   ent_p0.mem_we = 1'b1;
         default: ;
      endcase

      if (in_overflow) begin
         if (in_opcode == OP_ALU && in_aluop == ALU_ADD) begin
            ovf_hit_p0  = 1'b1;
            ovf_code_p0 = 2'(OVF_ADD);
         end else if (in_opcode == OP_ADDI) begin
            ovf_hit_p0  = 1'b1;
            ovf_code_p0 = 2'(OVF_ADDI);
         end else if (in_opcode == OP_ALU && in_aluop == ALU_SUB) begin
            ovf_hit_p0  = 1'b1;
            ovf_code_p0 = 2'(OVF_SUB);
         end
      end

      if (ovf_hit_p0) begin
         ent_p0.rd     = REG_W'(OVF_RD);
         ent_p0.result = DATA_W'(ovf_code_p0);
         ent_p0.reg_we = 1'b1;
      end

      if (ent_p0.rd == '0)
         ent_p0.reg_we = 1'b0;
   end

   assign taken_p0 = accept_p0 &&
                     ((in_opcode == OP_BNE && in_not_equal) ||
                      (in_opcode == OP_BLT && in_less_than));

   ex_mem_skid #(.T(entry_t)) u_skid (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (ent_p0),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (head_p1)
   );

   assign out_rd         = head_p1.rd;
   assign out_result     = head_p1.result;
   assign out_store_data = head_p1.store_data;
   assign out_reg_we     = head_p1.reg_we;
   assign out_mem_we     = head_p1.mem_we;
   assign out_mem_re     = head_p1.mem_re;

   // Redirect register: target only reloads on a taken, unflushed accept
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else if (flush) begin
         redirect_valid <= 1'b0;
      end else begin
         redirect_valid <= taken_p0;
         if (taken_p0)
            redirect_pc <= in_branch_target;
      end
   end

`ifdef EX_MEM_OVF_COUNT_EN
   function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Overflow counter: survives flush, counts only accepts that land
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         ovf_count <= '0;
      else if (accept_p0 && ovf_hit_p0 && !flush)
         ovf_count <= sat_inc(ovf_count);
   end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed-vector bench for ex_mem_stage with
// hand-computed expected values. Build with +define+EX_MEM_OVF_COUNT_EN to
// include the overflow-counter checks.
module tb_ex_mem_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_opcode;
   logic [4:0]  in_aluop;
   logic [4:0]  in_rd;
   logic [31:0] in_alu_result;
   logic        in_not_equal;
   logic        in_less_than;
   logic        in_overflow;
   logic [31:0] in_store_data;
   logic [31:0] in_branch_target;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_rd;
   logic [31:0] out_result;
   logic [31:0] out_store_data;
   logic        out_reg_we;
   logic        out_mem_we;
   logic        out_mem_re;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
`ifdef EX_MEM_OVF_COUNT_EN
   logic [15:0] ovf_count;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clock = ~clock;

   ex_mem_stage dut (
      .clock            (clock),
      .reset            (reset),
      .flush            (flush),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_opcode        (in_opcode),
      .in_aluop         (in_aluop),
      .in_rd            (in_rd),
      .in_alu_result    (in_alu_result),
      .in_not_equal     (in_not_equal),
      .in_less_than     (in_less_than),
      .in_overflow      (in_overflow),
      .in_store_data    (in_store_data),
      .in_branch_target (in_branch_target),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_rd           (out_rd),
      .out_result       (out_result),
      .out_store_data   (out_store_data),
      .out_reg_we       (out_reg_we),
      .out_mem_we       (out_mem_we),
      .out_mem_re       (out_mem_re),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc)
`ifdef EX_MEM_OVF_COUNT_EN
      ,
      .ovf_count        (ovf_count)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just past it
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic [4:0] op, input logic [4:0] aop, input logic [4:0] rd,
                        input logic [31:0] res, input logic ne, input logic lt,
                        input logic ovf, input logic [31:0] sd, input logic [31:0] tgt);
      in_valid         = 1'b1;
      in_opcode        = op;
      in_aluop         = aop;
      in_rd            = rd;
      in_alu_result    = res;
      in_not_equal     = ne;
      in_less_than     = lt;
      in_overflow      = ovf;
      in_store_data    = sd;
      in_branch_target = tgt;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      flush = 1'b0;
      out_ready = 1'b0;
      drive(5'b00000, 5'b00000, 5'd5, 32'h55, 1'b1, 1'b1, 1'b0, 32'h0, 32'h44);

      // Reset held with a valid input present
      step();
      step();
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_redirect_valid", redirect_valid, 0);
      check("rst_redirect_pc", redirect_pc, 0);
      check("rst_out_result", out_result, 0);
      check("rst_out_reg_we", out_reg_we, 0);
`ifdef EX_MEM_OVF_COUNT_EN
      check("rst_ovf_count", ovf_count, 0);
`endif

      reset = 1'b1;
      out_ready = 1'b1;
      drive(5'b00000, 5'b00000, 5'd5, 32'h12, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      check("add_valid", out_valid, 1);
      check("add_rd", out_rd, 5);
      check("add_result", out_result, 32'h12);
      check("add_reg_we", out_reg_we, 1);
      check("add_mem_we", out_mem_we, 0);
      idle();
      step();
      check("add_popped", out_valid, 0);

      // Backpressure: A, B fill the buffer, C waits upstream
      out_ready = 1'b0;
      drive(5'b00000, 5'b00000, 5'd1, 32'hA1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      check("bp_ready_after_a", in_ready, 1);
      drive(5'b00000, 5'b00000, 5'd2, 32'hB2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      check("bp_ready_after_b", in_ready, 0);
      check("bp_head_a", out_rd, 1);
      drive(5'b00000, 5'b00000, 5'd3, 32'hC3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      check("bp_c_held", in_ready, 0);
      check("bp_head_still_a", out_result, 32'hA1);
      out_ready = 1'b1;
      step();
      check("bp_head_b", out_rd, 2);
      check("bp_head_b_res", out_result, 32'hB2);
      check("bp_ready_reopen", in_ready, 1);
      step();
      idle();
      check("bp_head_c", out_rd, 3);
      check("bp_head_c_res", out_result, 32'hC3);
      check("bp_c_valid", out_valid, 1);
      step();
      check("bp_drained", out_valid, 0);

      // Overflow rewrites and non-rewrites
      drive(5'b00000, 5'b00000, 5'd7, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      step();
      check("ovf_add_rd", out_rd, 30);
      check("ovf_add_res", out_result, 1);
      check("ovf_add_we", out_reg_we, 1);
      drive(5'b00101, 5'b00000, 5'd8, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      step();
      check("ovf_addi_rd", out_rd, 30);
      check("ovf_addi_res", out_result, 2);
      drive(5'b00000, 5'b00001, 5'd9, 32'h1234, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      step();
      check("ovf_sub_rd", out_rd, 30);
      check("ovf_sub_res", out_result, 3);
      drive(5'b00111, 5'b00000, 5'd4, 32'h100, 1'b0, 1'b0, 1'b1, 32'hDEAD, 32'h0);
      step();
      check("sw_ovf_rd", out_rd, 4);
      check("sw_ovf_res", out_result, 32'h100);
      check("sw_mem_we", out_mem_we, 1);
      check("sw_reg_we", out_reg_we, 0);
      check("sw_store_data", out_store_data, 32'hDEAD);
      drive(5'b01000, 5'b00000, 5'd9, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      check("lw_mem_re", out_mem_re, 1);
      check("lw_reg_we", out_reg_we, 1);
      check("lw_mem_we", out_mem_we, 0);
      idle();
      step();

      // Branches
      drive(5'b00010, 5'b00000, 5'd3, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h40);
      step();
      idle();
      check("bne_redirect", redirect_valid, 1);
      check("bne_pc", redirect_pc, 32'h40);
      check("bne_reg_we", out_reg_we, 0);
      check("bne_valid", out_valid, 1);
      step();
      check("bne_pulse_end", redirect_valid, 0);
      drive(5'b00110, 5'b00000, 5'd3, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h80);
      step();
      idle();
      check("blt_not_taken", redirect_valid, 0);
      check("blt_valid", out_valid, 1);
      step();

      // rd = 0 suppresses the register write
      drive(5'b00000, 5'b00000, 5'd0, 32'h99, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      idle();
      check("rd0_reg_we", out_reg_we, 0);
      check("rd0_result", out_result, 32'h99);
      step();

      // Flush at count 1 discards a concurrent taken-branch accept
      out_ready = 1'b0;
      drive(5'b00000, 5'b00000, 5'd1, 32'h11, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      drive(5'b00010, 5'b00000, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h60);
      flush = 1'b1;
      step();
      flush = 1'b0;
      idle();
      check("fl1_out_valid", out_valid, 0);
      check("fl1_in_ready", in_ready, 1);
      check("fl1_redirect", redirect_valid, 0);
      check("fl1_pc_kept", redirect_pc, 32'h40);

      // Flush at count 2 with a taken branch presented
      drive(5'b00000, 5'b00000, 5'd1, 32'h21, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      drive(5'b00000, 5'b00000, 5'd2, 32'h22, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      check("fl2_full", in_ready, 0);
      drive(5'b00010, 5'b00000, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h70);
      flush = 1'b1;
      step();
      flush = 1'b0;
      idle();
      check("fl2_out_valid", out_valid, 0);
      check("fl2_in_ready", in_ready, 1);
      check("fl2_redirect", redirect_valid, 0);
`ifdef EX_MEM_OVF_COUNT_EN
      check("ovf_count_after_flush", ovf_count, 3);
`endif

      // Buffer restarts cleanly after flush
      drive(5'b00000, 5'b00000, 5'd11, 32'hBB, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      idle();
      check("post_flush_valid", out_valid, 1);
      check("post_flush_rd", out_rd, 11);
      out_ready = 1'b1;
      step();
      check("post_flush_drained", out_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
